sync_fifo_flag: RTL and testbench

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It is the same-clock-domain successor to the team's dual-clock FIFO, for buffering inside one clock domain. Typical placements are between pipeline stages and in front of narrow consumers. DEPTH need not be a power of two.

---
 rtl/sync_fifo_flag.sv | 162 ++++++++++++++++
 tb/tb_sync_fifo_flag.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flag.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and optional first-word-fall-through read.
//
// Parameters:
//   WIDTH      data word width
//   DEPTH      number of entries (>= 2, any integer)
//   ADDR_WIDTH pointer width, at least $clog2(DEPTH)
//   AFULL_TH   almost_full when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
//   FWFT       0: registered read, 1: first-word-fall-through
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   winc, wdata        write request and data
//   rinc               read request (FWFT: pop the shown word)
//   rdata, rvalid      read data and its valid
//   wfull, rempty      count == DEPTH / count == 0
//   almost_full/empty  threshold flags
//   count              occupancy 0..DEPTH
//   overflow/underflow one-cycle pulse on a rejected request
module sync_fifo_flag #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AFULL_TH   = DEPTH - 4,
    parameter int AEMPTY_TH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  winc,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  rinc,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = CW'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = CW'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    // Elaboration-time parameter legality.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flag: DEPTH must be >= 2");
    end
    if (ADDR_WIDTH < $clog2(DEPTH)) begin : g_bad_aw
        $error("sync_fifo_flag: ADDR_WIDTH too small for DEPTH");
    end
    if (AEMPTY_TH < 1 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH)
    begin : g_bad_th
        $error("sync_fifo_flag: need 1 <= AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic [WIDTH-1:0]      rd_word;

    // DEPTH need not be a power of two, so wrap by compare.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Flags decode the registered count only.
    assign wfull        = (count_q == CNT_FULL);
    assign rempty       = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses pre-edge state: full+both pops only,
    // empty+both pushes only.
    assign wr_acc = winc && !wfull;
    assign rd_acc = rinc && !rempty;

    assign rd_word = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (rd_acc) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= winc && wfull;
            underflow_q <= rinc && rempty;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; gated to zero while empty so
        // stale contents never appear after reset.
        assign rdata  = rempty ? '0 : rd_word;
        assign rvalid = !rempty;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= rd_word;
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flag.sv
// Self-checking bench for sync_fifo_flag: standard 16-deep,
// 12-deep wrap, and FWFT instances with queue scoreboards.
module tb_sync_fifo_flag;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // DEPTH=16 standard
    logic       w16, r16;
    logic [7:0] wd16, rd16;
    logic       rv16, full16, emp16, af16, ae16, ov16, un16;
    logic [4:0] cnt16;

    // DEPTH=12 standard
    logic       w12, r12;
    logic [7:0] wd12, rd12;
    logic       rv12, full12, emp12, af12, ae12, ov12, un12;
    logic [4:0] cnt12;

    // DEPTH=16 FWFT
    logic       wfw, rfw;
    logic [7:0] wdfw, rdfw;
    logic       rvfw, fullfw, empfw, affw, aefw, ovfw, unfw;
    logic [4:0] cntfw;

    logic [7:0] q16[$];
    logic [7:0] q12[$];
    int         m16 = 0;
    int         m12 = 0;

    sync_fifo_flag #(
        .WIDTH(8), .DEPTH(16), .AFULL_TH(12),
        .AEMPTY_TH(4), .FWFT(0)
    ) u_d16 (
        .clk(clk), .rstn(rstn),
        .winc(w16), .wdata(wd16), .rinc(r16),
        .rdata(rd16), .rvalid(rv16),
        .wfull(full16), .rempty(emp16),
        .almost_full(af16), .almost_empty(ae16),
        .count(cnt16),
        .overflow(ov16), .underflow(un16)
    );

    sync_fifo_flag #(
        .WIDTH(8), .DEPTH(12), .FWFT(0)
    ) u_d12 (
        .clk(clk), .rstn(rstn),
        .winc(w12), .wdata(wd12), .rinc(r12),
        .rdata(rd12), .rvalid(rv12),
        .wfull(full12), .rempty(emp12),
        .almost_full(af12), .almost_empty(ae12),
        .count(cnt12),
        .overflow(ov12), .underflow(un12)
    );

    sync_fifo_flag #(
        .WIDTH(8), .DEPTH(16), .FWFT(1)
    ) u_fw (
        .clk(clk), .rstn(rstn),
        .winc(wfw), .wdata(wdfw), .rinc(rfw),
        .rdata(rdfw), .rvalid(rvfw),
        .wfull(fullfw), .rempty(empfw),
        .almost_full(affw), .almost_empty(aefw),
        .count(cntfw),
        .overflow(ovfw), .underflow(unfw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        w16 = 0; r16 = 0; wd16 = 0;
        w12 = 0; r12 = 0; wd12 = 0;
        wfw = 0; rfw = 0; wdfw = 0;
        #12;
        vec++;
        if ({cnt16, emp16, full16, af16, ae16, rv16, ov16, un16}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset16: got %b want %b",
                {cnt16, emp16, full16, af16, ae16, rv16, ov16, un16},
                {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        vec++;
        if (rd16 !== 8'h00) begin
            errs++;
            $display("FAIL reset_rdata16: got %0h want 0", rd16);
        end
        vec++;
        if ({cnt12, emp12, full12, rv12} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset12: got %b want %b",
                {cnt12, emp12, full12, rv12}, {5'd0, 1'b1, 1'b0, 1'b0});
        end
        vec++;
        if ({cntfw, empfw, rvfw} !== {5'd0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL reset_fw: got %b want %b",
                {cntfw, empfw, rvfw}, {5'd0, 1'b1, 1'b0});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic exp_ov;
        for (int i = 1; i <= 17; i++) begin
            w16 = 1'b1;
            wd16 = 8'(i);
            exp_ov = (m16 == 16);
            if (!exp_ov) begin
                q16.push_back(8'(i));
                m16++;
            end
            tick();
            vec++;
            if (cnt16 !== 5'(m16)) begin
                errs++;
                $display("FAIL fill_count: got %0d want %0d", cnt16, m16);
            end
            vec++;
            if ({full16, af16, ae16, ov16} !==
                {m16 == 16, m16 >= 12, m16 <= 4, exp_ov}) begin
                errs++;
                $display("FAIL fill_flags(full,af,ae,ov): got %b want %b",
                    {full16, af16, ae16, ov16},
                    {m16 == 16, m16 >= 12, m16 <= 4, exp_ov});
            end
        end
        w16 = 1'b0;
        tick();
        vec++;
        if ({ov16, full16, cnt16} !== {1'b0, 1'b1, 5'd16}) begin
            errs++;
            $display("FAIL fill_ov_clear: got %b want %b",
                {ov16, full16, cnt16}, {1'b0, 1'b1, 5'd16});
        end
    endtask

    task automatic test_drain();
        logic       exp_rv;
        logic [7:0] exp;
        for (int i = 0; i < 17; i++) begin
            exp_rv = (m16 > 0);
            r16 = 1'b1;
            tick();
            r16 = 1'b0;
            vec++;
            if (exp_rv) begin
                m16--;
                exp = q16.pop_front();
                if ({rv16, rd16, un16} !== {1'b1, exp, 1'b0}) begin
                    errs++;
                    $display("FAIL drain_read(rv,rd,un): got %0h want %0h",
                        {rv16, rd16, un16}, {1'b1, exp, 1'b0});
                end
            end else begin
                if ({rv16, un16} !== 2'b01) begin
                    errs++;
                    $display("FAIL drain_underflow(rv,un): got %b want 01",
                        {rv16, un16});
                end
            end
            vec++;
            if (cnt16 !== 5'(m16)) begin
                errs++;
                $display("FAIL drain_count: got %0d want %0d", cnt16, m16);
            end
            tick();
            vec++;
            if ({rv16, un16} !== 2'b00) begin
                errs++;
                $display("FAIL drain_pulse_end(rv,un): got %b want 00",
                    {rv16, un16});
            end
        end
        vec++;
        if ({emp16, cnt16} !== {1'b1, 5'd0}) begin
            errs++;
            $display("FAIL drain_empty: got %b want %b",
                {emp16, cnt16}, {1'b1, 5'd0});
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            w16 = 1'b1;
            wd16 = 8'h40 + 8'(i);
            q16.push_back(wd16);
            m16++;
            tick();
        end
        w16 = 1'b0;
        vec++;
        if (full16 !== 1'b1) begin
            errs++;
            $display("FAIL sim_full: got %b want 1", full16);
        end
        w16 = 1'b1; wd16 = 8'hEE; r16 = 1'b1;
        tick();
        w16 = 1'b0; r16 = 1'b0;
        m16--;
        exp = q16.pop_front();
        vec++;
        if ({cnt16, ov16, rv16, rd16} !== {5'd15, 1'b1, 1'b1, exp}) begin
            errs++;
            $display("FAIL sim_full_both(cnt,ov,rv,rd): got %0h want %0h",
                {cnt16, ov16, rv16, rd16}, {5'd15, 1'b1, 1'b1, exp});
        end
        r16 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            m16--;
            exp = q16.pop_front();
            vec++;
            if ({rv16, rd16} !== {1'b1, exp}) begin
                errs++;
                $display("FAIL sim_drain(rv,rd): got %0h want %0h",
                    {rv16, rd16}, {1'b1, exp});
            end
        end
        r16 = 1'b0;
        tick();
        w16 = 1'b1; wd16 = 8'h90; r16 = 1'b1;
        tick();
        w16 = 1'b0; r16 = 1'b0;
        q16.push_back(8'h90);
        m16 = 1;
        vec++;
        if ({cnt16, un16, rv16} !== {5'd1, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL sim_empty_both(cnt,un,rv): got %b want %b",
                {cnt16, un16, rv16}, {5'd1, 1'b1, 1'b0});
        end
        for (int i = 0; i < 7; i++) begin
            w16 = 1'b1;
            wd16 = 8'h91 + 8'(i);
            q16.push_back(wd16);
            m16++;
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            w16 = 1'b1; r16 = 1'b1;
            wd16 = 8'hA0 + 8'(i);
            q16.push_back(wd16);
            tick();
            exp = q16.pop_front();
            vec++;
            if ({cnt16, rv16, rd16} !== {5'd8, 1'b1, exp}) begin
                errs++;
                $display("FAIL sim_steady(cnt,rv,rd): got %0h want %0h",
                    {cnt16, rv16, rd16}, {5'd8, 1'b1, exp});
            end
        end
        w16 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = q16.pop_front();
            vec++;
            if ({rv16, rd16} !== {1'b1, exp}) begin
                errs++;
                $display("FAIL sim_tail(rv,rd): got %0h want %0h",
                    {rv16, rd16}, {1'b1, exp});
            end
        end
        r16 = 1'b0;
        m16 = 0;
        tick();
        vec++;
        if ({emp16, cnt16, rv16} !== {1'b1, 5'd0, 1'b0}) begin
            errs++;
            $display("FAIL sim_final_empty: got %b want %b",
                {emp16, cnt16, rv16}, {1'b1, 5'd0, 1'b0});
        end
    endtask

    task automatic test_wrap12();
        logic [7:0] exp;
        int         nread;
        int         nwrite;
        for (int ph = 0; ph < 4; ph++) begin
            nwrite = (ph == 0) ? 12 : (ph == 2) ? 8 : 0;
            nread  = (ph == 1) ? 8 : (ph == 3) ? 12 : 0;
            for (int i = 0; i < nwrite; i++) begin
                w12 = 1'b1;
                wd12 = 8'(ph * 16 + i + 8'h20);
                q12.push_back(wd12);
                m12++;
                tick();
                vec++;
                if ({full12, cnt12} !== {m12 == 12, 5'(m12)}) begin
                    errs++;
                    $display("FAIL wrap_write(full,cnt): got %b want %b",
                        {full12, cnt12}, {m12 == 12, 5'(m12)});
                end
            end
            w12 = 1'b0;
            for (int i = 0; i < nread; i++) begin
                r12 = 1'b1;
                tick();
                m12--;
                exp = q12.pop_front();
                vec++;
                if ({rv12, rd12, cnt12} !== {1'b1, exp, 5'(m12)}) begin
                    errs++;
                    $display("FAIL wrap_read(rv,rd,cnt): got %0h want %0h",
                        {rv12, rd12, cnt12}, {1'b1, exp, 5'(m12)});
                end
            end
            r12 = 1'b0;
        end
        tick();
        vec++;
        if ({emp12, rv12} !== 2'b10) begin
            errs++;
            $display("FAIL wrap_end(emp,rv): got %b want 10", {emp12, rv12});
        end
    endtask

    task automatic test_fwft();
        logic [7:0] qfw[$];
        logic [7:0] exp;
        wfw = 1'b1; wdfw = 8'hA5;
        tick();
        wfw = 1'b0;
        vec++;
        if ({rdfw, rvfw, empfw} !== {8'hA5, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL fwft_show(rd,rv,emp): got %0h want %0h",
                {rdfw, rvfw, empfw}, {8'hA5, 1'b1, 1'b0});
        end
        rfw = 1'b1;
        tick();
        rfw = 1'b0;
        vec++;
        if ({empfw, rvfw} !== 2'b10) begin
            errs++;
            $display("FAIL fwft_pop(emp,rv): got %b want 10", {empfw, rvfw});
        end
        for (int i = 0; i < 3; i++) begin
            wfw = 1'b1;
            wdfw = 8'hB0 + 8'(i);
            qfw.push_back(wdfw);
            tick();
            vec++;
            if ({rdfw, rvfw} !== {8'hB0, 1'b1}) begin
                errs++;
                $display("FAIL fwft_head(rd,rv): got %0h want %0h",
                    {rdfw, rvfw}, {8'hB0, 1'b1});
            end
        end
        wfw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = qfw.pop_front();
            vec++;
            if ({rdfw, rvfw} !== {exp, 1'b1}) begin
                errs++;
                $display("FAIL fwft_order(rd,rv): got %0h want %0h",
                    {rdfw, rvfw}, {exp, 1'b1});
            end
            rfw = 1'b1;
            tick();
        end
        rfw = 1'b0;
        vec++;
        if ({empfw, rvfw, cntfw} !== {1'b1, 1'b0, 5'd0}) begin
            errs++;
            $display("FAIL fwft_empty: got %b want %b",
                {empfw, rvfw, cntfw}, {1'b1, 1'b0, 5'd0});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            w16 = 1'b1;
            wd16 = 8'h60 + 8'(i);
            tick();
        end
        w16 = 1'b0;
        r16 = 1'b1;
        tick();
        r16 = 1'b0;
        vec++;
        if ({cnt16, rv16, rd16} !== {5'd7, 1'b1, 8'h60}) begin
            errs++;
            $display("FAIL mid_pre(cnt,rv,rd): got %0h want %0h",
                {cnt16, rv16, rd16}, {5'd7, 1'b1, 8'h60});
        end
        #3;
        rstn = 1'b0;
        #1;
        q16.delete();
        m16 = 0;
        vec++;
        if ({cnt16, emp16, ae16, rv16, rd16}
            !== {5'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            errs++;
            $display("FAIL mid_async(cnt,emp,ae,rv,rd): got %0h want %0h",
                {cnt16, emp16, ae16, rv16, rd16},
                {5'd0, 1'b1, 1'b1, 1'b0, 8'h00});
        end
        #2;
        rstn = 1'b1;
        tick();
        w16 = 1'b1; wd16 = 8'h77;
        tick();
        w16 = 1'b0; r16 = 1'b1;
        tick();
        r16 = 1'b0;
        vec++;
        if ({rv16, rd16, cnt16} !== {1'b1, 8'h77, 5'd0}) begin
            errs++;
            $display("FAIL mid_after(rv,rd,cnt): got %0h want %0h",
                {rv16, rd16, cnt16}, {1'b1, 8'h77, 5'd0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap12();
        test_fwft();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
